// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Requester id width; a single bit is kept even for tiny requester counts.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_wr_arbiter_rr_picker.sv
// rtl/fifo_rr_wr_arbiter_rr_picker.sv - combinational rotating-priority encoder
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // Scan start, start+1, ... wrapping by subtraction so N need not be a power of 2.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(start) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// rtl/fifo_rr_wr_arbiter.sv - round-robin bounded-burst arbiter feeding one FIFO write port
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4,
  localparam int IDW      = id_width(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [WIDTH-1:0]     i_req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_fifo_wr_en,
  output logic [IDW+WIDTH-1:0] o_fifo_data,
  input  logic                 i_fifo_full,
  output logic [IDW-1:0]       o_grant_id,
  output logic                 o_busy
);

  localparam int CW = $clog2(BURST_MAX + 1);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [CW-1:0]  burst_cnt, burst_cnt_nxt;

  logic           in_grant, valid_g, beat, release_g, pick_found;
  logic [IDW-1:0] owner_inc, pick_start, pick_idx;

  always_comb begin
    in_grant   = (state == GRANT);
    owner_inc  = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + IDW'(1);
    valid_g    = i_req_valid[owner];
    beat       = in_grant & valid_g & ~i_fifo_full;
    release_g  = in_grant & ((beat & (burst_cnt == CW'(BURST_MAX - 1))) | ~valid_g);
    pick_start = in_grant ? owner_inc : rr_ptr;
  end

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_picker (
    .req   (i_req_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt     = GRANT;
          owner_nxt     = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (release_g) begin
          // Same-cycle re-arbitration gives back-to-back grants with no bubble.
          rr_ptr_nxt    = owner_inc;
          burst_cnt_nxt = '0;
          if (pick_found) owner_nxt = pick_idx;
          else            state_nxt = IDLE;
        end else if (beat) begin
          burst_cnt_nxt = burst_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (in_grant) o_req_ready[owner] = ~i_fifo_full;
    o_fifo_wr_en = beat;
    o_fifo_data  = in_grant ? {owner, i_req_data[owner]} : '0;
    o_grant_id   = in_grant ? owner : '0;
    o_busy       = in_grant;
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// tb/tb_fifo_rr_wr_arbiter.sv - directed self-checking bench for fifo_rr_wr_arbiter
module tb_fifo_rr_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Instance A: NUM_REQ=4, BURST_MAX=4
  logic [3:0] a_valid = '0, a_ready;
  logic [7:0] a_data [4];
  logic       a_wr, a_full = 1'b0, a_busy;
  logic [9:0] a_fdata;
  logic [1:0] a_gid;

  // Instance B: NUM_REQ=4, BURST_MAX=2
  logic [3:0] b_valid = '0, b_ready;
  logic [7:0] b_data [4];
  logic       b_wr, b_busy;
  logic [9:0] b_fdata;
  logic [1:0] b_gid;

  // Instance C: NUM_REQ=3, BURST_MAX=1
  logic [2:0] c_valid = '0, c_ready;
  logic [7:0] c_data [3];
  logic       c_wr, c_busy;
  logic [9:0] c_fdata;
  logic [1:0] c_gid;

  fifo_rr_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_MAX(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(a_valid), .i_req_data(a_data),
    .o_req_ready(a_ready), .o_fifo_wr_en(a_wr), .o_fifo_data(a_fdata),
    .i_fifo_full(a_full), .o_grant_id(a_gid), .o_busy(a_busy));

  fifo_rr_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_MAX(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(b_valid), .i_req_data(b_data),
    .o_req_ready(b_ready), .o_fifo_wr_en(b_wr), .o_fifo_data(b_fdata),
    .i_fifo_full(1'b0), .o_grant_id(b_gid), .o_busy(b_busy));

  fifo_rr_wr_arbiter #(.NUM_REQ(3), .WIDTH(8), .BURST_MAX(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(c_valid), .i_req_data(c_data),
    .o_req_ready(c_ready), .o_fifo_wr_en(c_wr), .o_fifo_data(c_fdata),
    .i_fifo_full(1'b0), .o_grant_id(c_gid), .o_busy(c_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Producer-side rule on A plus the one-hot-ready and no-write-when-full invariants.
  logic [3:0] pv = '0, pr = '0;
  logic [7:0] pd [4];
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && !pr[i]) begin
          vectors++;
          assert (a_valid[i] === 1'b1 && a_data[i] === pd[i])
          else begin
            miscompares++;
            $error("FAIL producer_hold[%0d] observed=%b/0x%0h expected=1/0x%0h", i, a_valid[i], a_data[i], pd[i]);
          end
        end
      end
      vectors++;
      assert ($countones(a_ready) <= 1 && !(a_wr && a_full))
      else begin
        miscompares++;
        $error("FAIL a_invariant observed=ready %b wr %b full %b expected=onehot0 and no write when full", a_ready, a_wr, a_full);
      end
    end
    pv <= a_valid;
    pr <= a_ready;
    for (int i = 0; i < 4; i++) pd[i] <= a_data[i];
  end

  logic [1:0] b_exp [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
  logic [1:0] c_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_data[i] = '0;
      b_data[i] = 8'(i);
    end
    for (int i = 0; i < 3; i++) c_data[i] = 8'hC0 + 8'(i);

    repeat (2) @(posedge clk);
    #3;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_wr", a_wr, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_gid", a_gid, 0);
    chk("rst_a_data", a_fdata, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_c_busy", c_busy, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single producer: four beats, no-bubble re-grant, two more beats
    a_valid = 4'b0100; a_data[2] = 8'hA0;
    #1;
    chk("t1_idle_ready", a_ready, 0);
    chk("t1_idle_wr", a_wr, 0);
    tick;
    chk("t1_busy", a_busy, 1);
    chk("t1_gid", a_gid, 2);
    for (int k = 0; k < 6; k++) begin
      a_data[2] = 8'hA0 + 8'(k);
      #1;
      chk("t1_wr", a_wr, 1);
      chk("t1_data", a_fdata, 32'h2A0 + k);
      chk("t1_ready", a_ready, 4'b0100);
      if (k == 4) begin
        chk("t1_regrant_gid", a_gid, 2);
        chk("t1_regrant_cnt", u_a.burst_cnt, 0);
      end
      tick;
    end
    a_valid = 4'b0000;
    #1;
    chk("t1_drop_wr", a_wr, 0);
    tick;
    chk("t1_idle_busy", a_busy, 0);
    chk("t1_idle_gid", a_gid, 0);
    chk("t1_rr_ptr", u_a.rr_ptr, 3);

    // Early release of owner 3 with wrap to requester 0
    a_data[3] = 8'h33; a_data[0] = 8'h11; a_valid = 4'b1001;
    #1;
    tick;
    chk("t2_gid3", a_gid, 3);
    chk("t2_data3", a_fdata, 32'h333);
    tick;
    a_valid = 4'b0001;
    #1;
    chk("t2_drop_wr", a_wr, 0);
    chk("t2_drop_ready", a_ready, 4'b1000);
    chk("t2_drop_busy", a_busy, 1);
    tick;
    chk("t2_gid0", a_gid, 0);
    chk("t2_data0", a_fdata, 32'h011);
    chk("t2_wr0", a_wr, 1);

    // Full backpressure on owner 1 mid-burst
    a_data[1] = 8'hB0; a_valid = 4'b0011;
    tick;
    a_valid = 4'b0010;
    #1;
    chk("t3_drop0_wr", a_wr, 0);
    tick;
    chk("t3_gid1", a_gid, 1);
    chk("t3_dataB0", a_fdata, 32'h1B0);
    chk("t3_wrB0", a_wr, 1);
    tick;
    a_data[1] = 8'hB1;
    #1;
    chk("t3_cnt1", u_a.burst_cnt, 1);
    a_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_full_ready", a_ready, 0);
      chk("t3_full_wr", a_wr, 0);
      chk("t3_full_cnt", u_a.burst_cnt, 1);
      chk("t3_full_gid", a_gid, 1);
      tick;
    end
    a_full = 1'b0;
    for (int k = 1; k < 4; k++) begin
      a_data[1] = 8'hB0 + 8'(k);
      #1;
      chk("t3_resume_wr", a_wr, 1);
      chk("t3_resume_data", a_fdata, 32'h1B0 + k);
      tick;
    end
    chk("t3_rel_cnt", u_a.burst_cnt, 0);
    chk("t3_rel_gid", a_gid, 1);
    chk("t3_rel_ptr", u_a.rr_ptr, 2);
    a_valid = 4'b0000;
    #1;
    tick;
    chk("t3_idle", a_busy, 0);

    // Reset while owner 2 holds burst_cnt=2
    a_data[2] = 8'hC0; a_data[0] = 8'h55; a_valid = 4'b0101;
    #1;
    tick;
    for (int k = 0; k < 2; k++) begin
      a_data[2] = 8'hC0 + 8'(k);
      #1;
      chk("t4_data", a_fdata, 32'h2C0 + k);
      tick;
    end
    a_data[2] = 8'hC2;
    #1;
    chk("t4_cnt2", u_a.burst_cnt, 2);
    chk("t4_gid2", a_gid, 2);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ready", a_ready, 0);
    chk("t4_rst_wr", a_wr, 0);
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_gid", a_gid, 0);
    #2;
    rst_n = 1'b1;
    tick;
    chk("t4_post_gid", a_gid, 0);
    chk("t4_post_busy", a_busy, 1);
    chk("t4_post_data", a_fdata, 32'h055);
    chk_en = 1'b0;
    a_valid = 4'b0000;

    // All four valid, BURST_MAX=2
    b_valid = 4'b1111;
    #1;
    tick;
    for (int j = 0; j < 9; j++) begin
      #1;
      chk("b_gid", b_gid, b_exp[j]);
      chk("b_ready", b_ready, 32'(4'b0001 << b_exp[j]));
      chk("b_data", b_fdata, {22'd0, b_exp[j], 6'd0, b_exp[j]});
      chk("b_wr", b_wr, 1);
      tick;
    end
    b_valid = 4'b0000;

    // Three requesters, BURST_MAX=1: rotate every beat, id 3 never used
    c_valid = 3'b111;
    #1;
    tick;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("c_gid", c_gid, c_exp[j]);
      chk("c_ready", c_ready, 32'(3'b001 << c_exp[j]));
      chk("c_data", c_fdata, (32'(c_exp[j]) << 8) | (32'hC0 + 32'(c_exp[j])));
      tick;
    end
    c_valid = 3'b000;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
